// File: rtl/des_pkg.sv
// Shared DES constants and FSM encoding for the Feistel encrypt/decrypt sequencers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package des_pkg;

  // Rounds per block and width of each Feistel half.
  localparam int NUM_ROUNDS = 16;
  localparam int HALF_W     = 32;

  // Subkey index width (K1..K16 -> 0..15).
  localparam int KEY_IDX_W  = 4;

  // Round counter width; one spare bit so the counter can step past the last round.
  localparam int RND_W      = 5;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/feistel_half_reg.sv
// L/R half-block register pair with load, round and hold controls.
// Latency: load and round updates take effect on the next rising edge.
// Backpressure: none here; the owner decides when to load or round, otherwise the pair holds.
module feistel_half_reg #(
  parameter int HALF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              round,
  input  logic [HALF_W-1:0] ld_l,
  input  logic [HALF_W-1:0] ld_r,
  input  logic [HALF_W-1:0] f_in,
  output logic [HALF_W-1:0] l,
  output logic [HALF_W-1:0] r
);

  // Load wins over round; with neither asserted both halves hold their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l <= '0;
      r <= '0;
    end else if (load) begin
      l <= ld_l;
      r <= ld_r;
    end else if (round) begin
      l <= r;
      r <= l ^ f_in;
    end
  end

endmodule

// File: rtl/feistel_dec_seq.sv
// Sequential Feistel decryptor: one round per cycle, subkeys applied K16 down to K1.
// Latency: out_valid rises NUM_ROUNDS cycles after the accepting edge.
// Backpressure: result holds in DONE until out_ready; new input accepted only in IDLE.
module feistel_dec_seq
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = des_pkg::NUM_ROUNDS,
  parameter int HALF_W     = des_pkg::HALF_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HALF_W-1:0]    ct_L,
  input  logic [HALF_W-1:0]    ct_R,
  output logic [HALF_W-1:0]    f_R,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [HALF_W-1:0]    f_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [HALF_W-1:0]    pt_L,
  output logic [HALF_W-1:0]    pt_R,
  output logic                 busy
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  fsm_state_t         state;
  logic [RND_W-1:0]   rnd;
  logic [RND_W-1:0]   rnd_rev;
  logic               load;
  logic               round_en;
  logic [HALF_W-1:0]  l_q;
  logic [HALF_W-1:0]  r_q;

  // in_ready is registered and only ever high in IDLE, so this is the handshake.
  assign load     = in_valid && in_ready;
  // f_in is consumed only while rounds are running.
  assign round_en = (state == ST_ROUND);

  feistel_half_reg #(
    .HALF_W (HALF_W)
  ) u_half_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .round (round_en),
    .ld_l  (ct_L),
    .ld_r  (ct_R),
    .f_in  (f_in),
    .l     (l_q),
    .r     (r_q)
  );

  // Round rnd uses subkey NUM_ROUNDS-1-rnd; outside ROUND the index is parked at 0.
  assign rnd_rev = LAST_RND - rnd;
  assign key_idx = round_en ? rnd_rev[KEY_IDX_W-1:0] : '0;
  assign f_R     = r_q;

  // The final swap is just a rewiring: R16 goes left, L16 goes right.
  assign pt_L = r_q;
  assign pt_R = l_q;

  // Sequencer: state, round counter and the registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rnd       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            rnd      <= '0;
            state    <= ST_ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_ROUND: begin
          // The counter steps every round; on the last one it parks past the end
          // and is only reloaded by the next IDLE handshake.
          rnd <= rnd + RND_W'(1);
          if (rnd == LAST_RND) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feistel_dec_seq.sv
// Directed bench for feistel_dec_seq with a reference DES f-function on the f port.
// Latency: expects out_valid 16 cycles after the accepting edge.
// Backpressure: exercises out_ready stalls and ignored in_valid while busy.
module tb_feistel_dec_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ct_L;
  logic [31:0] ct_R;
  logic [31:0] f_R;
  logic [3:0]  key_idx;
  logic [31:0] f_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pt_L;
  logic [31:0] pt_R;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic        use_des;
  logic [31:0] f_fixed;
  logic [47:0] subkeys [16];

  feistel_dec_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_L      (ct_L),
    .ct_R      (ct_R),
    .f_R       (f_R),
    .key_idx   (key_idx),
    .f_in      (f_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_L      (pt_L),
    .pt_R      (pt_R),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference DES model ----------------
  int ip_t [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int fp_t [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int e_t  [48] = '{32,1,2,3,4,5,     4,5,6,7,8,9,     8,9,10,11,12,13,
                    12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                    24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_t  [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                    2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  int pc1_t [56] = '{57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
                     10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29,  21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5,   3,28,15,6,21,10,
                     23,19,12,4,26,8,   16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48,
                     44,49,39,56,34,53, 46,42,50,36,29,32};
  int shift_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  // Each S-box packed row-major, entry 0 in the top nibble.
  logic [255:0] sbox [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-ip_t[i]];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-fp_t[i]];
    return y;
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b6;
    int          idx;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-e_t[i]];
    e = e ^ k;
    for (int b = 0; b < 8; b++) begin
      b6  = e[47-6*b -: 6];
      idx = 32'({b6[5], b6[0]}) * 16 + 32'(b6[4:1]);
      s[31-4*b -: 4] = sbox[b][255-4*idx -: 4];
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-p_t[i]];
    return p;
  endfunction

  task automatic gen_keys(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] k;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < shift_t[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-pc2_t[i]];
      subkeys[r] = k;
    end
  endtask

  // External f-function: reference DES f with the selected subkey, or a fixed value.
  assign f_in = use_des ? des_f(f_R, subkeys[key_idx]) : f_fixed;

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send(input logic [31:0] l, input logic [31:0] r);
    in_valid = 1'b1;
    ct_L     = l;
    ct_R     = r;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (pt_L !== 32'h0) begin n_fail++; $display("FAIL reset_pt_L got %h want 0", pt_L); end
    n_checks++; if (pt_R !== 32'h0) begin n_fail++; $display("FAIL reset_pt_R got %h want 0", pt_R); end
    n_checks++; if (key_idx !== 4'd0) begin n_fail++; $display("FAIL reset_key_idx got %0d want 0", key_idx); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_f;
    int cyc;
    use_des = 1'b0;
    f_fixed = 32'h0;
    send(32'h01234567, 32'h89ABCDEF);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zf_busy got %b want 1", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL zf_in_ready got %b want 0", in_ready); end
    n_checks++; if (key_idx !== 4'd15) begin n_fail++; $display("FAIL zf_first_key got %0d want 15", key_idx); end
    wait_done(cyc);
    n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL zf_latency got %0d want 16", cyc); end
    n_checks++; if (pt_L !== 32'h89ABCDEF) begin n_fail++; $display("FAIL zf_pt_L got %h want 89abcdef", pt_L); end
    n_checks++; if (pt_R !== 32'h01234567) begin n_fail++; $display("FAIL zf_pt_R got %h want 01234567", pt_R); end
    n_checks++; if (key_idx !== 4'd0) begin n_fail++; $display("FAIL zf_done_key got %0d want 0", key_idx); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zf_ready_after got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zf_idle_after got vld=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_subkey_order;
    logic [3:0] seen [$];
    int guard;
    use_des = 1'b0;
    f_fixed = 32'h0;
    send(32'hCAFEF00D, 32'h0BADBEEF);
    guard = 0;
    while (out_valid !== 1'b1 && guard < 40) begin
      if (busy === 1'b1) seen.push_back(key_idx);
      @(negedge clk);
      guard++;
    end
    n_checks++; if (seen.size() !== 16) begin n_fail++; $display("FAIL key_count got %0d want 16", seen.size()); end
    for (int i = 0; i < seen.size() && i < 16; i++) begin
      n_checks++;
      if (seen[i] !== 4'(15 - i)) begin n_fail++; $display("FAIL key_order[%0d] got %0d want %0d", i, seen[i], 15 - i); end
    end
    @(negedge clk);
  endtask

  task automatic test_kat;
    int cyc;
    logic [63:0] ipx;
    logic [63:0] res;
    use_des = 1'b1;
    ipx = des_ip(64'h85E813540F0AB405);
    send(ipx[63:32], ipx[31:0]);
    wait_done(cyc);
    res = des_fp({pt_L, pt_R});
    n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL kat_latency got %0d want 16", cyc); end
    n_checks++; if (res !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL kat_plain got %h want 0123456789abcdef", res); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int cyc;
    use_des   = 1'b0;
    f_fixed   = 32'h0;
    out_ready = 1'b0;
    send(32'hA5A50F0F, 32'h3C3CF0F0);
    wait_done(cyc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || pt_L !== 32'h3C3CF0F0 || pt_R !== 32'hA5A50F0F) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b %h_%h want 1 0 3c3cf0f0_a5a50f0f", i, out_valid, in_ready, pt_L, pt_R);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_ignored_input;
    int cyc;
    logic [63:0] ipx;
    logic [63:0] res;
    use_des = 1'b1;
    ipx = des_ip(64'h85E813540F0AB405);
    send(ipx[63:32], ipx[31:0]);
    repeat (4) @(negedge clk);
    in_valid = 1'b1;
    ct_L     = 32'hFFFFFFFF;
    ct_R     = 32'h12345678;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    wait_done(cyc);
    res = des_fp({pt_L, pt_R});
    n_checks++; if (cyc + 6 !== 16) begin n_fail++; $display("FAIL ign_latency got %0d want 16", cyc + 6); end
    n_checks++; if (res !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL ign_plain got %h want 0123456789abcdef", res); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int cyc;
    logic [63:0] ipx;
    logic [63:0] res;
    use_des = 1'b1;
    ipx = des_ip(64'h85E813540F0AB405);
    send(ipx[63:32], ipx[31:0]);
    repeat (7) @(negedge clk);
    n_checks++; if (key_idx !== 4'd8) begin n_fail++; $display("FAIL rst_round7_key got %0d want 8", key_idx); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_ctl got vld=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready); end
    n_checks++; if (pt_L !== 32'h0 || pt_R !== 32'h0) begin n_fail++; $display("FAIL rst_async_data got %h_%h want 0_0", pt_L, pt_R); end
    n_checks++; if (key_idx !== 4'd0) begin n_fail++; $display("FAIL rst_async_key got %0d want 0", key_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    send(ipx[63:32], ipx[31:0]);
    wait_done(cyc);
    res = des_fp({pt_L, pt_R});
    n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL rst_next_latency got %0d want 16", cyc); end
    n_checks++; if (res !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL rst_next_plain got %h want 0123456789abcdef", res); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    use_des  = 1'b0;
    f_fixed  = 32'h0;
    in_valid = 1'b1;
    ct_L     = 32'h11111111;
    ct_R     = 32'h22222222;
    @(negedge clk);
    ct_L = 32'h33333333;
    ct_R = 32'h44444444;
    wait_done(cyc);
    n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL b2b_lat1 got %0d want 16", cyc); end
    n_checks++; if (pt_L !== 32'h22222222 || pt_R !== 32'h11111111) begin n_fail++; $display("FAIL b2b_res1 got %h_%h want 22222222_11111111", pt_L, pt_R); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got rdy=%b busy=%b want 1 0", in_ready, busy); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got rdy=%b busy=%b want 0 1", in_ready, busy); end
    wait_done(cyc);
    n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL b2b_lat2 got %0d want 16", cyc); end
    n_checks++; if (pt_L !== 32'h44444444 || pt_R !== 32'h33333333) begin n_fail++; $display("FAIL b2b_res2 got %h_%h want 44444444_33333333", pt_L, pt_R); end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    ct_L      = 32'h0;
    ct_R      = 32'h0;
    out_ready = 1'b1;
    use_des   = 1'b0;
    f_fixed   = 32'h0;
    gen_keys(64'h133457799BBCDFF1);
    #12;
    test_reset;
    test_zero_f;
    test_subkey_order;
    test_kat;
    test_backpressure;
    test_ignored_input;
    test_reset_mid_op;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/feistel_dec_seq.md
FEISTEL_DEC_SEQ -- requirements
Module: feistel_dec_seq

Interface
REQ-001 Parameter NUM_ROUNDS, default 16: number of Feistel rounds per block.
REQ-002 Parameter HALF_W, default 32: width of each Feistel half-block.
REQ-003 clk  input  1  single clock for the block; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low; the block SHALL be reset while rst_n==0.
REQ-005 in_valid  input  1  ciphertext halves present on ct_L/ct_R.
REQ-006 in_ready  output  1  block can accept a new ciphertext block.
REQ-007 ct_L  input  32  left half of the ciphertext, after the initial permutation.
REQ-008 ct_R  input  32  right half of the ciphertext, after the initial permutation.
REQ-009 f_R  output  32  R operand driven to the external f-function.
REQ-010 key_idx  output  4  subkey index driven to the key store; 0 selects K1 and 15 selects K16.
REQ-011 f_in  input  32  f(f_R, K[key_idx]) result; combinational and valid in the same cycle.
REQ-012 out_valid  output  1  preoutput block is available on pt_L/pt_R.
REQ-013 out_ready  input  1  consumer accepts the preoutput block.
REQ-014 pt_L  output  32  left half of the swapped preoutput (R16), before the final permutation.
REQ-015 pt_R  output  32  right half of the swapped preoutput (L16), before the final permutation.
REQ-016 busy  output  1  high in the ROUND and DONE states.

Function
REQ-017 The FSM SHALL have three states: IDLE, ROUND and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 out_valid SHALL be 1 only in DONE.
REQ-020 In IDLE, when in_valid&in_ready: load L<=ct_L, R<=ct_R and rnd<=0, and go to ROUND. With no handshake, IDLE SHALL hold all registers.
REQ-021 In ROUND, each cycle: R<=L^f_in, L<=R, rnd<=rnd+1.
REQ-022 The combinational outputs SHALL be f_R=R and key_idx=NUM_ROUNDS-1-rnd, giving the subkey order K16 down to K1.
REQ-023 In ROUND, when rnd==NUM_ROUNDS-1, the round update SHALL be performed and the state SHALL go to DONE.
REQ-024 pt_L=R and pt_R=L in every state; this is the final swap, and both values are stable while out_valid==1.
REQ-025 In DONE, when out_ready==1: go to IDLE. L and R are retained until the next load.
REQ-026 Latency: the handshake edge is E0; rounds execute on edges E1..E16; out_valid SHALL rise after E16, i.e. 16 cycles after the accepting edge.
REQ-027 There is no back-to-back acceptance: in_ready SHALL rise the cycle after the out_valid&out_ready edge.
REQ-028 in_valid asserted while the block is not in IDLE SHALL be ignored, with no effect on state.
REQ-029 In ROUND and DONE, f_in SHALL only be sampled in ROUND.
REQ-030 The rnd counter SHALL be 5 bits wide and SHALL never exceed NUM_ROUNDS-1 in ROUND.
REQ-031 rnd SHALL not wrap: it is reloaded only by the IDLE handshake.
REQ-032 In IDLE and DONE, key_idx SHALL be driven to 0 and f_R SHALL equal R. Consumers SHALL ignore both in these states.

Reset
REQ-033 While rst_n==0: state=IDLE, L=0, R=0, rnd=0.
REQ-034 Outputs during reset SHALL be in_ready=1, out_valid=0, busy=0, pt_L=0, pt_R=0, key_idx=0.
REQ-035 Reset asserted mid-ROUND or in DONE SHALL abandon the block immediately; no partial result SHALL be presented.
REQ-036 On the first edge after reset release, the block SHALL be able to accept a handshake.

Structure
REQ-037 Shared package des_pkg SHALL hold NUM_ROUNDS, HALF_W, the KEY_IDX_W=4 constant and the FSM state encoding. The same package is shared with the encrypt datapath.
REQ-038 One sub-module, feistel_half_reg, SHALL hold the L/R pair with load, round and hold controls. All sequencing SHALL be in feistel_dec_seq.

Verification
REQ-039 Zero-f: bench holds f_in=0 and sends ct_L=0x01234567, ct_R=0x89ABCDEF -> after 16 cycles out_valid=1 with pt_L=0x89ABCDEF, pt_R=0x01234567.
REQ-040 Subkey order: bench monitors key_idx across ROUND -> key_idx is 15,14,...,0, one value per cycle, with exactly 16 values.
REQ-041 Known-answer: bench uses the reference DES f-function and key schedule with key 0x133457799BBCDFF1 and the IP/FP models on ciphertext 0x85E813540F0AB405 -> the plaintext after FP is 0x0123456789ABCDEF.
REQ-042 Backpressure: bench holds out_ready=0 for 10 cycles in DONE -> pt_L/pt_R stay stable and in_ready stays 0; when out_ready goes to 1, in_ready rises on the next cycle.
REQ-043 Reset mid-op: bench drops rst_n at round 7 -> state returns to IDLE asynchronously with out_valid=0 and L=R=0. A following block then completes correctly.
REQ-044 Ignored input: bench pulses in_valid with new data during ROUND -> the result is unchanged versus the undisturbed run.
